// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction-memory port, decoder handshake and redirect/halt lines.
// The master modport is the fetch sequencer; the slave modport is memory plus the downstream stage.
interface fetch_ctrl_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic        i_decode_valid;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_halt;

    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_ack,
        input  i_imem_rdata,
        output o_instruction,
        output o_pc,
        output o_inst_valid,
        input  i_inst_ready,
        input  i_decode_valid,
        input  i_redirect,
        input  i_redirect_pc,
        output o_halt
    );

    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_ack,
        output i_imem_rdata,
        input  o_instruction,
        input  o_pc,
        input  o_inst_valid,
        output i_inst_ready,
        output i_decode_valid,
        output i_redirect,
        output i_redirect_pc,
        input  o_halt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, keeps one memory request in flight,
// hands each fetched word to decode and stops for good on an illegal opcode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         clk_en,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {bus.i_redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.i_imem_ack) begin
                    if (pend_q || bus.i_redirect) begin
                        // Word is stale: restart at the newest target, address changes only now
                        pc_d   = bus.i_redirect ? redirect_tgt : pend_pc_q;
                        pend_d = 1'b0;
                    end else begin
                        instr_d = bus.i_imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (bus.i_redirect) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_tgt;
                end
            end
            S_HOLD: begin
                if (bus.i_redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = S_FETCH;
                end else if (!bus.i_decode_valid) begin
                    state_d = S_HALT;
                end else if (bus.i_inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0000_0000;
        end else if (clk_en) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign bus.o_imem_req    = (state_q == S_FETCH);
    assign bus.o_imem_addr   = pc_q;
    assign bus.o_pc          = pc_q;
    assign bus.o_instruction = instr_q;
    assign bus.o_inst_valid  = (state_q == S_HOLD);
    assign bus.o_halt        = (state_q == S_HALT);
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scenario bench for fetch_ctrl: a memory responder with programmable wait states feeds the
// DUT, and every fetch expected to reach decode is queued and compared when it is presented.
module tb_fetch_ctrl;
    logic clk;
    logic clk_en;
    logic rst;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk    (clk),
        .clk_en (clk_en),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    int          wait_states = 0;
    int          wait_cnt;
    logic [31:0] illegal_addr = 32'hDEAD_BEE0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] bad);
        // ADDI-shaped word tagged with its address; the poisoned address returns all zeros
        return (a == bad) ? 32'h0000_0000 : {a[24:0], 7'h13};
    endfunction

    assign bus.i_imem_ack     = bus.o_imem_req && (wait_cnt >= wait_states);
    assign bus.i_imem_rdata   = mem_word(bus.o_imem_addr, illegal_addr);
    assign bus.i_decode_valid = (bus.o_instruction != 32'h0000_0000);

    always @(posedge clk) begin
        if (rst)
            wait_cnt <= 0;
        else if (clk_en)
            wait_cnt <= (bus.o_imem_req && !bus.i_imem_ack) ? wait_cnt + 1 : 0;
    end

    always @(negedge clk) begin
        if (!rst && clk_en && bus.o_inst_valid && bus.i_inst_ready && bus.i_decode_valid && !bus.i_redirect)
            $display("xfer pc=%h instr=%h", bus.o_pc, bus.o_instruction);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t t;
        t.pc    = a;
        t.instr = mem_word(a, illegal_addr);
        exp_q.push_back(t);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.o_imem_req !== 1'b0 || bus.o_inst_valid !== 1'b0 || bus.o_halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b valid=%b halt=%b, expected 0 0 0",
                     bus.o_imem_req, bus.o_inst_valid, bus.o_halt);
        end
        checks++;
        if (bus.o_imem_addr !== 32'h100 || bus.o_pc !== 32'h100) begin
            errors++;
            $display("FAIL reset_pc: addr=%h pc=%h, expected 00000100", bus.o_imem_addr, bus.o_pc);
        end
        checks++;
        if (bus.o_instruction !== 32'h0) begin
            errors++;
            $display("FAIL reset_instr: instr=%h, expected 00000000", bus.o_instruction);
        end
    endtask

    task automatic test_first_fetch;
        rst = 1'b0;
        checks++;
        if (bus.o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle0: req=%b, expected 0", bus.o_imem_req);
        end
        step();
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h, expected 1 00000100", bus.o_imem_req, bus.o_imem_addr);
        end
        push_exp(32'h100);
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== e.pc || bus.o_instruction !== e.instr) begin
            errors++;
            $display("FAIL first_valid: valid=%b pc=%h instr=%h, expected 1 %h %h",
                     bus.o_inst_valid, bus.o_pc, bus.o_instruction, e.pc, e.instr);
        end
        step();
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h104 || bus.o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL next_req: req=%b addr=%h valid=%b, expected 1 00000104 0",
                     bus.o_imem_req, bus.o_imem_addr, bus.o_inst_valid);
        end
        push_exp(32'h104);
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== e.pc || bus.o_instruction !== e.instr) begin
            errors++;
            $display("FAIL second_valid: valid=%b pc=%h instr=%h, expected 1 %h %h",
                     bus.o_inst_valid, bus.o_pc, bus.o_instruction, e.pc, e.instr);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        held_pc    = 32'h104;
        held_instr = mem_word(32'h104, illegal_addr);
        bus.i_inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== held_pc || bus.o_instruction !== held_instr
                || bus.o_imem_req !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b pc=%h instr=%h req=%b, expected 1 %h %h 0",
                         i, bus.o_inst_valid, bus.o_pc, bus.o_instruction, bus.o_imem_req, held_pc, held_instr);
            end
        end
        bus.i_inst_ready = 1'b1;
        step();
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h108) begin
            errors++;
            $display("FAIL backpressure_release: req=%b addr=%h, expected 1 00000108",
                     bus.o_imem_req, bus.o_imem_addr);
        end
        push_exp(32'h108);
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== e.pc || bus.o_instruction !== e.instr) begin
            errors++;
            $display("FAIL backpressure_next: valid=%b pc=%h instr=%h, expected 1 %h %h",
                     bus.o_inst_valid, bus.o_pc, bus.o_instruction, e.pc, e.instr);
        end
    endtask

    task automatic test_redirect_in_fetch;
        wait_states = 3;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h200;
        step();
        bus.i_redirect = 1'b0;
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h200 || bus.i_imem_ack !== 1'b0) begin
            errors++;
            $display("FAIL redir_fetch_start: req=%b addr=%h ack=%b, expected 1 00000200 0",
                     bus.o_imem_req, bus.o_imem_addr, bus.i_imem_ack);
        end
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h403;
        step();
        bus.i_redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h200 || bus.o_inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL redir_addr_stable[%0d]: req=%b addr=%h valid=%b, expected 1 00000200 0",
                         i, bus.o_imem_req, bus.o_imem_addr, bus.o_inst_valid);
            end
            step();
        end
        wait_states = 0;
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h400 || bus.o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_target: req=%b addr=%h valid=%b, expected 1 00000400 0",
                     bus.o_imem_req, bus.o_imem_addr, bus.o_inst_valid);
        end
        push_exp(32'h400);
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== e.pc || bus.o_instruction !== e.instr) begin
            errors++;
            $display("FAIL redir_target_valid: valid=%b pc=%h instr=%h, expected 1 %h %h",
                     bus.o_inst_valid, bus.o_pc, bus.o_instruction, e.pc, e.instr);
        end
    endtask

    task automatic test_redirect_with_ready;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h10;
        step();
        bus.i_redirect = 1'b0;
        push_exp(32'h10);
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== e.pc || bus.o_instruction !== e.instr) begin
            errors++;
            $display("FAIL redir_ready_setup: valid=%b pc=%h instr=%h, expected 1 %h %h",
                     bus.o_inst_valid, bus.o_pc, bus.o_instruction, e.pc, e.instr);
        end
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h80;
        step();
        bus.i_redirect = 1'b0;
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h80 || bus.o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_ready_target: req=%b addr=%h valid=%b, expected 1 00000080 0",
                     bus.o_imem_req, bus.o_imem_addr, bus.o_inst_valid);
        end
        push_exp(32'h80);
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== e.pc || bus.o_instruction !== e.instr) begin
            errors++;
            $display("FAIL redir_ready_valid: valid=%b pc=%h instr=%h, expected 1 %h %h",
                     bus.o_inst_valid, bus.o_pc, bus.o_instruction, e.pc, e.instr);
        end
    endtask

    task automatic test_wrap;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'hFFFF_FFFE;
        step();
        bus.i_redirect = 1'b0;
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_align: req=%b addr=%h, expected 1 fffffffc", bus.o_imem_req, bus.o_imem_addr);
        end
        push_exp(32'hFFFF_FFFC);
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== e.pc || bus.o_instruction !== e.instr) begin
            errors++;
            $display("FAIL wrap_top_valid: valid=%b pc=%h instr=%h, expected 1 %h %h",
                     bus.o_inst_valid, bus.o_pc, bus.o_instruction, e.pc, e.instr);
        end
        step();
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero: req=%b addr=%h, expected 1 00000000", bus.o_imem_req, bus.o_imem_addr);
        end
        push_exp(32'h0);
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== e.pc || bus.o_instruction !== e.instr) begin
            errors++;
            $display("FAIL wrap_zero_valid: valid=%b pc=%h instr=%h, expected 1 %h %h",
                     bus.o_inst_valid, bus.o_pc, bus.o_instruction, e.pc, e.instr);
        end
    endtask

    task automatic test_clk_en;
        step();
        clk_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h4 || bus.o_inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL clk_en_hold[%0d]: req=%b addr=%h valid=%b, expected 1 00000004 0",
                         i, bus.o_imem_req, bus.o_imem_addr, bus.o_inst_valid);
            end
        end
        clk_en = 1'b1;
        push_exp(32'h4);
        step();
        e = exp_q.pop_front();
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_pc !== e.pc || bus.o_instruction !== e.instr) begin
            errors++;
            $display("FAIL clk_en_resume: valid=%b pc=%h instr=%h, expected 1 %h %h",
                     bus.o_inst_valid, bus.o_pc, bus.o_instruction, e.pc, e.instr);
        end
    endtask

    task automatic test_halt;
        illegal_addr      = 32'h300;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h300;
        step();
        bus.i_redirect = 1'b0;
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL halt_fetch: req=%b addr=%h, expected 1 00000300", bus.o_imem_req, bus.o_imem_addr);
        end
        step();
        checks++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_instruction !== 32'h0 || bus.o_halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_present: valid=%b instr=%h halt=%b, expected 1 00000000 0",
                     bus.o_inst_valid, bus.o_instruction, bus.o_halt);
        end
        step();
        checks++;
        if (bus.o_halt !== 1'b1 || bus.o_inst_valid !== 1'b0 || bus.o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: halt=%b valid=%b req=%b, expected 1 0 0",
                     bus.o_halt, bus.o_inst_valid, bus.o_imem_req);
        end
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h500;
        step();
        bus.i_redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.o_halt !== 1'b1 || bus.o_imem_req !== 1'b0 || bus.o_pc !== 32'h300) begin
                errors++;
                $display("FAIL halt_sticky[%0d]: halt=%b req=%b pc=%h, expected 1 0 00000300",
                         i, bus.o_halt, bus.o_imem_req, bus.o_pc);
            end
            step();
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.o_halt !== 1'b0 || bus.o_pc !== 32'h100 || bus.o_imem_req !== 1'b0 || bus.o_instruction !== 32'h0) begin
            errors++;
            $display("FAIL halt_reset: halt=%b pc=%h req=%b instr=%h, expected 0 00000100 0 00000000",
                     bus.o_halt, bus.o_pc, bus.o_imem_req, bus.o_instruction);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL halt_restart: req=%b addr=%h, expected 1 00000100", bus.o_imem_req, bus.o_imem_addr);
        end
    endtask

    initial begin
        rst               = 1'b1;
        clk_en            = 1'b1;
        bus.i_inst_ready  = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'h0;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_in_fetch();
        test_redirect_with_ready();
        test_wrap();
        test_clk_en();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
